nios_simple_pio_edge_in: RTL and testbench

NIOS_SIMPLE_PIO_EDGE_IN -- requirements
Module: nios_simple_pio_edge_in

---
 rtl/nios_simple_pio_pkg.sv | 13 +
 rtl/nios_simple_pio_sync.sv | 26 ++
 rtl/nios_simple_pio_edge_in.sv | 117 +++++++++++
 tb/tb_nios_simple_pio_edge_in.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_simple_pio_pkg.sv
// Shared constants for the simple PIO edge-capture input port: register
// addresses and edge-type selector values.
package nios_simple_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_simple_pio_sync.sv
// Per-bit multi-flop synchronizer for asynchronous PIO inputs.
// Latency: SYNC_STAGES cycles. No backpressure; samples every cycle.
// Reset: asynchronous active-low, all stages clear to 0.
module nios_simple_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_simple_pio_edge_in.sv
// Avalon-MM PIO input port with edge capture; PIO_EDGE_IRQ_EN adds irqmask + irq.
// Latency: reads 1 cycle; capture SYNC_STAGES+1 cycles after an input edge; irq 1 cycle later.
// Backpressure: none; slave is always ready, readdata refreshes every cycle.
module nios_simple_pio_edge_in
    import nios_simple_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] event_w;
    logic [WIDTH-1:0] clear_w;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en;
    logic             unused_wdat;

    nios_simple_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .async_i (in_port),
        .sync_o  (sync_in)
    );

    // Upper writedata bits beyond WIDTH are deliberately dropped.
    assign unused_wdat = ^writedata;

    always_comb begin
        wr_en  = chipselect & ~write_n;
        rise_w = sync_in & ~prev_q;
        fall_w = ~sync_in & prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            event_w = fall_w;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            event_w = rise_w | fall_w;
        end else begin
            event_w = rise_w;
        end
        clear_w = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        // New events are ORed in after the clear so a same-cycle set wins.
        edgecap_d = (edgecap_q & ~clear_w) | event_w;
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;

    always_comb begin
        irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
        end
    end
`else
    always_comb begin
        irq_d = 1'b0;
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
`ifdef PIO_EDGE_IRQ_EN
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
`endif
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= sync_in;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_simple_pio_edge_in.sv
// Directed bench: rising-edge instance (2 sync stages) plus any-edge instance (3 sync stages).
module tb_nios_simple_pio_edge_in;

`ifdef PIO_EDGE_IRQ_EN
    localparam logic [31:0] IRQ_EXP  = 32'd1;
    localparam logic [31:0] MASK_EXP = 32'h08;
`else
    localparam logic [31:0] IRQ_EXP  = 32'd0;
    localparam logic [31:0] MASK_EXP = 32'h00;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [7:0]  in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_simple_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    nios_simple_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port2),
        .readdata   (readdata2),
        .irq        (irq2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    initial begin
        reset_n    = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hA5;
        in_port2   = 8'h00;
        #2 reset_n = 1'b0;
        repeat (3) step();
        chk("rst_rd", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rd2", readdata2, 32'h0);

        reset_n = 1'b1;
        repeat (5) step();
        chk("data_rd", readdata, 32'h0000_00A5);
        chk("irq_nomask", {31'h0, irq}, 32'h0);
        address = 2'd1;
        step();
        chk("rsvd_rd", readdata, 32'h0);
        address = 2'd3;
        step();
        chk("edgecap_boot", readdata, 32'h0000_00A5);

        bus_write(2'd0, 32'h0000_00FF);
        step();
        chk("data_ro", readdata, 32'h0000_00A5);
        bus_write(2'd1, 32'hFFFF_FFFF);
        step();
        chk("rsvd_wr", readdata, 32'h0);

        bus_write(2'd3, 32'hFFFF_FFFF);
        chk("w1c_lat", readdata, 32'h0000_00A5);
        step();
        chk("w1c_clr", readdata, 32'h0);

        bus_write(2'd2, 32'hFFFF_FF08);
        step();
        chk("mask_rd", readdata, MASK_EXP);

        // Rising edge on bit 3 with two sync stages.
        address = 2'd3;
        in_port = 8'hAD;
        repeat (3) step();
        chk("cap_early", readdata, 32'h0);
        chk("irq_early", {31'h0, irq}, 32'h0);
        step();
        chk("cap_b3", readdata, 32'h08);
        chk("irq_set", {31'h0, irq}, IRQ_EXP);

        writedata  = 32'hFFFF_FFFF;
        chipselect = 1'b0;
        write_n    = 1'b0;
        step();
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chipselect = 1'b0;
        step();
        chk("no_strobe", readdata, 32'h08);

        bus_write(2'd3, 32'hFFFF_FFFF);
        chk("irq_hold", {31'h0, irq}, IRQ_EXP);
        step();
        chk("irq_clr", {31'h0, irq}, 32'h0);
        chk("cap_clr", readdata, 32'h0);

        in_port = 8'h8D;
        repeat (4) step();
        chk("fall_ign", readdata, 32'h0);

        // Bit 5 rises; its event coincides with a W1C of bit 5.
        in_port = 8'hAD;
        step();
        step();
        bus_write(2'd3, 32'h0000_0020);
        address = 2'd3;
        step();
        chk("set_wins", readdata, 32'h20);
        chk("irq_masked", {31'h0, irq}, 32'h0);

        bus_write(2'd3, 32'h0000_0008);
        step();
        chk("w1c_other", readdata, 32'h20);

        in_port = 8'hAF;
        step();
        step();
        in_port = 8'hAD;
        repeat (4) step();
        chk("pulse2", readdata, 32'h22);

        bus_write(2'd3, 32'hFFFF_FFFF);
        step();
        chk("any_idle", readdata2, 32'h0);

        in_port2 = 8'h01;
        repeat (4) step();
        chk("any_early", readdata2, 32'h0);
        step();
        chk("any_rise", readdata2, 32'h01);
        bus_write(2'd3, 32'h0000_0001);
        step();
        chk("any_clr1", readdata2, 32'h0);

        in_port2 = 8'h00;
        repeat (5) step();
        chk("any_fall", readdata2, 32'h01);
        bus_write(2'd3, 32'h0000_0001);
        step();
        chk("any_clr2", readdata2, 32'h0);

        in_port2 = 8'h01;
        repeat (5) step();
        chk("any_rise2", readdata2, 32'h01);
        chk("any_irq", {31'h0, irq2}, 32'h0);
        chk("rise_iso", readdata, 32'h0);

        #2 reset_n = 1'b0;
        #1;
        chk("arst_rd2", readdata2, 32'h0);
        step();
        address = 2'd2;
        reset_n = 1'b1;
        step();
        chk("arst_mask", readdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
